// File: rtl/audio_i2s_tx.sv
// I2S transmitter: divides clk into BCLK, frames stereo samples MSB-first with LRCLK
// leading data by one bit clock, fed from a one-deep holding register.
module audio_i2s_tx #(
   parameter int HALF_DIV  = 1,
   parameter int SLOT_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [SLOT_BITS-1:0] sample_left,
   input  logic [SLOT_BITS-1:0] sample_right,
   input  logic                 sample_valid,
   output logic                 sample_ready,
   output logic                 underrun,
   output logic                 i2s_bclk,
   output logic                 i2s_lrclk,
   output logic                 i2s_sdata
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int BW         = $clog2(FRAME_BITS);
   localparam int DW         = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int SW         = FRAME_BITS - 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] LR_FIRST = BW'(SLOT_BITS - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);

   logic [DW-1:0]        div_cnt_r;
   logic [BW-1:0]        bit_cnt_r;
   logic                 hold_full_r;
   logic [SLOT_BITS-1:0] hold_left_r;
   logic [SLOT_BITS-1:0] hold_right_r;
   logic [SW-1:0]        shreg_r;
   logic                 bclk_r;
   logic                 lrclk_r;
   logic                 sdata_r;
   logic                 underrun_r;

   logic                 div_wrap_s;
   logic                 fall_s;
   logic                 load_s;
   logic                 accept_s;
   logic [BW-1:0]        bit_inc_s;

   // Decode the bit-clock events that drive framing and the holding-register handshake.
   always_comb begin
      div_wrap_s = en && (div_cnt_r == DIV_LAST);
      fall_s     = div_wrap_s && bclk_r;
      if (bit_cnt_r == BIT_LAST) begin
         bit_inc_s = {BW{1'b0}};
      end else begin
         bit_inc_s = bit_cnt_r + BW'(1'b1);
      end
      load_s   = fall_s && (bit_inc_s == {BW{1'b0}});
      accept_s = sample_valid && !hold_full_r;
   end

   // Holding register: accepts a pair when empty, emptied by a frame load; survives en=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_full_r  <= 1'b0;
         hold_left_r  <= {SLOT_BITS{1'b0}};
         hold_right_r <= {SLOT_BITS{1'b0}};
         underrun_r   <= 1'b0;
      end else begin
         underrun_r <= load_s && !hold_full_r;
         if (accept_s) begin
            hold_full_r  <= 1'b1;
            hold_left_r  <= sample_left;
            hold_right_r <= sample_right;
         end else if (load_s) begin
            hold_full_r  <= 1'b0;
         end else begin
            hold_full_r  <= hold_full_r;
         end
      end
   end

   // Serial engine: bit clock divider, frame position, word select and data shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r <= {DW{1'b0}};
         bit_cnt_r <= BIT_LAST;
         bclk_r    <= 1'b0;
         lrclk_r   <= 1'b0;
         sdata_r   <= 1'b0;
         shreg_r   <= {SW{1'b0}};
      end else if (!en) begin
         // Idle lines and rewind so the next enable starts a fresh frame.
         div_cnt_r <= {DW{1'b0}};
         bit_cnt_r <= BIT_LAST;
         bclk_r    <= 1'b0;
         lrclk_r   <= 1'b0;
         sdata_r   <= 1'b0;
      end else begin
         if (div_wrap_s) begin
            div_cnt_r <= {DW{1'b0}};
            bclk_r    <= !bclk_r;
         end else begin
            div_cnt_r <= div_cnt_r + DW'(1'b1);
         end
         if (fall_s) begin
            bit_cnt_r <= bit_inc_s;
            lrclk_r   <= (bit_inc_s >= LR_FIRST) && (bit_inc_s != BIT_LAST);
            if (load_s && hold_full_r) begin
               sdata_r <= hold_left_r[SLOT_BITS-1];
               shreg_r <= {hold_left_r[SLOT_BITS-2:0], hold_right_r};
            end else if (load_s) begin
               sdata_r <= 1'b0;
               shreg_r <= {SW{1'b0}};
            end else begin
               sdata_r <= shreg_r[SW-1];
               shreg_r <= {shreg_r[SW-2:0], 1'b0};
            end
         end
      end
   end

   assign sample_ready = !hold_full_r;
   assign underrun     = underrun_r;
   assign i2s_bclk     = bclk_r;
   assign i2s_lrclk    = lrclk_r;
   assign i2s_sdata    = sdata_r;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: two instances (16-bit/HALF_DIV=1 and 24-bit/HALF_DIV=3) checked
// every cycle against an arithmetic model of bit-clock position and frame contents.
module tb_audio_i2s_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, valid;
   logic [15:0] l0, r0;
   logic [23:0] l1, r1;
   logic        rdy0, ur0, bclk0, lr0, sd0;
   logic        rdy1, ur1, bclk1, lr1, sd1;

   audio_i2s_tx #(.HALF_DIV(1), .SLOT_BITS(16)) dut0 (
      .clk(clk), .rst(rst), .en(en), .sample_left(l0), .sample_right(r0),
      .sample_valid(valid), .sample_ready(rdy0), .underrun(ur0),
      .i2s_bclk(bclk0), .i2s_lrclk(lr0), .i2s_sdata(sd0));

   audio_i2s_tx #(.HALF_DIV(3), .SLOT_BITS(24)) dut1 (
      .clk(clk), .rst(rst), .en(en), .sample_left(l1), .sample_right(r1),
      .sample_valid(valid), .sample_ready(rdy1), .underrun(ur1),
      .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_sdata(sd1));

   int checks = 0;
   int failures = 0;

   int          hd [2] = '{1, 3};
   int          sb [2] = '{16, 24};
   int          k  [2];
   logic        full [2];
   logic [47:0] held [2];
   logic [47:0] word [2];
   logic        e_bclk [2], e_lr [2], e_sd [2], e_ur [2], fell [2];
   logic [31:0] cap0;
   logic [47:0] cap1;
   int          acc0, hs0, ur_cnt;

   // k = enabled edges since (re)enable; toggles = k/HALF_DIV, falls = toggles/2.
   function automatic void model_step(int d, logic [47:0] lw, logic [47:0] rw);
      int  fr, fo, fn, t, b;
      logic of, ld;
      fr = 2 * sb[d];
      of = full[d];
      fell[d] = 1'b0;
      if (rst) begin
         k[d] = 0; full[d] = 1'b0; held[d] = 48'd0; word[d] = 48'd0;
         e_ur[d] = 1'b0; e_bclk[d] = 1'b0; e_lr[d] = 1'b0; e_sd[d] = 1'b0;
         return;
      end
      fo = (k[d] / hd[d]) / 2;
      k[d] = en ? k[d] + 1 : 0;
      fn = (k[d] / hd[d]) / 2;
      fell[d] = en && (fn > fo);
      ld = fell[d] && ((fn - 1) % fr == 0);
      e_ur[d] = ld && !of;
      if (ld) word[d] = of ? held[d] : 48'd0;
      if (valid && !of) begin
         full[d] = 1'b1;
         held[d] = (lw << sb[d]) | rw;
         if (d == 0) acc0++;
      end else if (ld && of) begin
         full[d] = 1'b0;
      end
      if (!en) begin
         e_bclk[d] = 1'b0; e_lr[d] = 1'b0; e_sd[d] = 1'b0;
      end else begin
         t = k[d] / hd[d];
         e_bclk[d] = (t % 2) == 1;
         if (fn == 0) begin
            e_sd[d] = 1'b0; e_lr[d] = 1'b0;
         end else begin
            b = (fn - 1) % fr;
            e_sd[d] = word[d][fr - 1 - b];
            e_lr[d] = (b >= sb[d] - 1) && (b <= fr - 2);
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      if (valid && rdy0) hs0++;
      model_step(0, {32'd0, l0}, {32'd0, r0});
      model_step(1, {24'd0, l1}, {24'd0, r1});
      @(posedge clk);
      #1;
      chk("d0_bclk",  bclk0, e_bclk[0]);
      chk("d0_lrclk", lr0,   e_lr[0]);
      chk("d0_sdata", sd0,   e_sd[0]);
      chk("d0_under", ur0,   e_ur[0]);
      chk("d0_ready", rdy0,  !full[0]);
      chk("d1_bclk",  bclk1, e_bclk[1]);
      chk("d1_lrclk", lr1,   e_lr[1]);
      chk("d1_sdata", sd1,   e_sd[1]);
      chk("d1_under", ur1,   e_ur[1]);
      chk("d1_ready", rdy1,  !full[1]);
      if (fell[0]) cap0 = {cap0[30:0], sd0};
      if (fell[1]) cap1 = {cap1[46:0], sd1};
      if (ur0 || ur1) ur_cnt++;
   endtask

   task automatic offer(input logic [15:0] a, input logic [15:0] b,
                        input logic [23:0] c, input logic [23:0] e);
      l0 = a; r0 = b; l1 = c; r1 = e;
      valid = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; valid = 1'b0;
      l0 = 16'd0; r0 = 16'd0; l1 = 24'd0; r1 = 24'd0;
      cap0 = 32'd0; cap1 = 48'd0; acc0 = 0; hs0 = 0; ur_cnt = 0;
      repeat (3) tick();
      chk("rst_ready", rdy0, 1'b1);
      chk("rst_sdata", sd0, 1'b0);

      // Known pair preloaded while idle, then one full frame per instance.
      rst = 1'b0;
      offer(16'hA5C3, 16'h0F01, 24'hA5C3F0, 24'h0F0107);
      en = 1'b1;
      repeat (64) tick();
      chk("frame0_bits", cap0, 32'hA5C30F01);
      ur_cnt = 0;
      repeat (64) tick();
      chk("underrun_once", ur_cnt, 1);
      chk("underrun_zero_frame", cap0, 32'h0);
      repeat (160) tick();
      chk("frame1_bits", cap1, 48'hA5C3F00F0107);

      // Mixer offering continuously: one accept per frame, no underrun.
      valid = 1'b1;
      repeat (2) begin
         l0 = 16'($urandom); r0 = 16'($urandom); l1 = 24'($urandom); r1 = 24'($urandom);
         tick();
      end
      ur_cnt = 0;
      repeat (400) begin
         l0 = 16'($urandom); r0 = 16'($urandom); l1 = 24'($urandom); r1 = 24'($urandom);
         tick();
      end
      valid = 1'b0;
      chk("stream_no_underrun", ur_cnt, 0);
      chk("handshake_count", hs0, acc0);

      // Sparse random offers with occasional enable drops.
      repeat (800) begin
         valid = ($urandom_range(0, 9) == 0);
         en = ($urandom_range(0, 149) != 0);
         l0 = 16'($urandom); r0 = 16'($urandom); l1 = 24'($urandom); r1 = 24'($urandom);
         tick();
      end
      valid = 1'b0;
      en = 1'b1;

      // Reset at bit 7 of the left slot, then a clean restart.
      rst = 1'b1; tick(); rst = 1'b0;
      offer(16'h1234, 16'h5678, 24'h123456, 24'h789ABC);
      repeat (16) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_bclk", bclk0, 1'b0);
      chk("midrst_lrclk", lr0, 1'b0);
      chk("midrst_sdata", sd0, 1'b0);
      chk("midrst_ready", rdy0, 1'b1);
      en = 1'b0;
      offer(16'h8001, 16'h7FFE, 24'h800001, 24'h7FFFFE);
      en = 1'b1;
      repeat (64) tick();
      chk("restart_bits", cap0, 32'h80017FFE);

      // Enable dropped mid-frame with a pair held; it leads the next frame.
      repeat (22) tick();
      offer(16'hC0DE, 16'h3F5A, 24'hC0DE00, 24'h3F5A11);
      en = 1'b0;
      repeat (10) tick();
      chk("idle_bclk", bclk0, 1'b0);
      chk("idle_held", rdy0, 1'b0);
      en = 1'b1;
      repeat (64) tick();
      chk("resume_bits", cap0, 32'hC0DE3F5A);
      repeat (224) tick();
      chk("resume_bits_24", cap1, 48'hC0DE003F5A11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
